arrow_key_debouncer: RTL
========================

Name: arrow_key_debouncer

Overview:
Front-end conditioning stage that sits directly upstream of the arrowspace game core and drives its key_pressed input. It synchronises raw active-low arrow push-buttons and debounces them. It encodes the single held button as a 4-bit key code (0 = no key) and guarantees that key_pressed returns to 0 between distinct presses, which the core relies on for press-edge detection.

Parameters:
NUM_KEYS, 4, number of raw buttons (1..15); button i maps to code i+1
DEBOUNCE_CYCLES, 4, consecutive identical samples required to commit a press or a release (>=1)
REPEAT_DELAY, 50, cycles held before the first auto-repeat strobe (used only with AUTO_REPEAT_EN)
REPEAT_PERIOD, 10, cycles between subsequent auto-repeat strobes (used only with AUTO_REPEAT_EN)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
btn_n  input  NUM_KEYS  raw asynchronous buttons, active low; bit0 up, bit1 down, bit2 left, bit3 right
key_pressed  output  4  debounced key code, held while key is held; 0 = none
key_strobe  output  1  one-cycle pulse on the cycle key_pressed changes from 0 to a nonzero code
key_multi  output  1  high while the synchronised sample has more than one button down

Interface decision: one clock, clk; reset is synchronous and active-high, named reset.

Behaviour:
- Synchroniser: 2-flop chain per bit, reset to all-ones (released). Sample s = ~sync_out.
- Encode: s one-hot -> code = index+1. s==0 -> code 0. More than one bit set -> code 0 and key_multi=1 (chords are treated as release).
- Registers: state, cand[3:0], cnt[$clog2(DEBOUNCE_CYCLES+1)-1:0]. Outputs are registered.
- IDLE: key_pressed=0. code!=0 -> ARM, cand=code, cnt=1.
- ARM: code==cand -> cnt++. When cnt reaches DEBOUNCE_CYCLES -> HELD, key_pressed=cand, key_strobe=1 for that one cycle. code==0 -> IDLE. Other nonzero code -> cand=code, cnt=1.
- HELD: key_pressed=cand. code!=cand (0, other key or chord) -> REL, cnt=1.
- REL: key_pressed stays cand. code==cand -> HELD (bounce absorbed). Otherwise cnt++; when cnt reaches DEBOUNCE_CYCLES -> IDLE, key_pressed=0.
- A direct switch from key A to key B always passes through IDLE: key_pressed=0 for >=1 cycle, then B re-arms, so B needs a full debounce.
- With DEBOUNCE_CYCLES==1: ARM commits on the first matching edge.
- Latency: raw press stable before edge E -> key_pressed valid after edge E+1+DEBOUNCE_CYCLES. Release has the same latency.
- key_strobe fires only on IDLE/ARM->HELD, never on REL->HELD.
- Reset (any state, mid-press included): state=IDLE, key_pressed=0, key_strobe=0, key_multi=0, cand=0, cnt=0, synchroniser=all-ones. A button still held after reset must re-debounce fully.
- No outputs are ever X after the first reset edge.

Optional Feature:
AUTO_REPEAT_EN:
- Defined: HELD keeps a repeat counter cleared on entry to HELD. key_strobe additionally pulses REPEAT_DELAY cycles after entry, then every REPEAT_PERIOD cycles while HELD. The counter is cleared on leaving HELD; REL->HELD restarts the delay. key_pressed is unaffected.
- Undefined: no repeat logic; REPEAT_* parameters are ignored; exactly one strobe per press.

Test Plan:
- Reset 2 cycles, btn_n=4'hF -> key_pressed=0, key_strobe=0, key_multi=0 throughout.
- btn_n=4'hE held 20 cycles (DEBOUNCE_CYCLES=4) -> key_pressed=1 exactly 6 edges after first low sample, one key_strobe pulse. Release -> key_pressed=0 six edges later.
- btn_n toggling E/F every cycle for 10 cycles, then steady F -> key_pressed stays 0, no strobe. Same glitching while HELD on code 2 -> key_pressed stays 2, no second strobe.
- Hold up (E) until committed, then switch directly to down (D) -> sequence 1, 0 (>=1 cycle), 2, with two strobes total.
- btn_n=4'hC (two keys) -> key_multi=1 after 2 edges, key_pressed=0 (or falls to 0 after release debounce if a key was held).
- Assert reset while key_pressed=3 and the button stays held -> key_pressed=0 on the next edge, returns to 3 after full debounce with a new strobe. With AUTO_REPEAT_EN, REPEAT_DELAY=8, REPEAT_PERIOD=3, hold 20 cycles -> strobes at HELD+0, +8, +11, +14, +17.

Source files
------------

// File: rtl/arrow_key_debouncer.sv
// Synchronises and debounces active-low arrow buttons into a 4-bit key code with press strobe.
// Optional AUTO_REPEAT_EN adds periodic strobes while a key stays held.
module arrow_key_debouncer #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_PERIOD   = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] btn_n,
    output logic [3:0]          key_pressed,
    output logic                key_strobe,
    output logic                key_multi
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DC = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_HELD, S_REL} state_t;

    logic [NUM_KEYS-1:0] r_sync1, r_sync2;
    state_t              r_state, w_state_nxt;
    logic [3:0]          r_cand, w_cand_nxt;
    logic [CW-1:0]       r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [NUM_KEYS-1:0] w_samp;
    logic [3:0]          w_code, w_kp_nxt;
    logic                w_any, w_multi, w_enter_held, w_rpt_fire;

    assign w_samp    = ~r_sync2;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign key_multi = w_multi;

    // Chords decode to "no key" so they behave like a release.
    always_comb begin
        w_code  = 4'd0;
        w_any   = 1'b0;
        w_multi = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (w_samp[i]) begin
                if (w_any) w_multi = 1'b1;
                w_any  = 1'b1;
                w_code = 4'(i + 1);
            end
        end
        if (w_multi) w_code = 4'd0;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cand_nxt   = r_cand;
        w_cnt_nxt    = r_cnt;
        w_enter_held = 1'b0;
        case (r_state)
            S_IDLE: if (w_code != 4'd0) begin
                w_cand_nxt = w_code;
                if (DEBOUNCE_CYCLES == 1) begin
                    w_state_nxt  = S_HELD;
                    w_enter_held = 1'b1;
                    w_cnt_nxt    = '0;
                end else begin
                    w_state_nxt = S_ARM;
                    w_cnt_nxt   = CW'(1);
                end
            end
            S_ARM: begin
                if (w_code == r_cand) begin
                    if (w_cnt_inc == DC) begin
                        w_state_nxt  = S_HELD;
                        w_enter_held = 1'b1;
                        w_cnt_nxt    = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end else if (w_code == 4'd0) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cand_nxt = w_code;
                    w_cnt_nxt  = CW'(1);
                end
            end
            S_HELD: if (w_code != r_cand) begin
                w_state_nxt = (DEBOUNCE_CYCLES == 1) ? S_IDLE : S_REL;
                w_cnt_nxt   = (DEBOUNCE_CYCLES == 1) ? '0 : CW'(1);
            end
            default: begin
                if (w_code == r_cand) begin
                    w_state_nxt = S_HELD;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_inc == DC) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
        endcase
        w_kp_nxt = (w_state_nxt == S_HELD || w_state_nxt == S_REL) ? w_cand_nxt : 4'd0;
    end

`ifdef AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    logic [RW-1:0] r_rpt, w_rpt_nxt;

    // Down-counter: reloaded with the delay on every entry to HELD, then with the period.
    always_comb begin
        w_rpt_nxt  = '0;
        w_rpt_fire = 1'b0;
        if (w_state_nxt == S_HELD && r_state != S_HELD) begin
            w_rpt_nxt = RW'(REPEAT_DELAY);
        end else if (w_state_nxt == S_HELD) begin
            if (r_rpt == RW'(1)) begin
                w_rpt_fire = 1'b1;
                w_rpt_nxt  = RW'(REPEAT_PERIOD);
            end else begin
                w_rpt_nxt = r_rpt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_rpt <= '0;
        else       r_rpt <= w_rpt_nxt;
    end
`else
    assign w_rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1     <= '1;
            r_sync2     <= '1;
            r_state     <= S_IDLE;
            r_cand      <= 4'd0;
            r_cnt       <= '0;
            key_pressed <= 4'd0;
            key_strobe  <= 1'b0;
        end else begin
            r_sync1     <= btn_n;
            r_sync2     <= r_sync1;
            r_state     <= w_state_nxt;
            r_cand      <= w_cand_nxt;
            r_cnt       <= w_cnt_nxt;
            key_pressed <= w_kp_nxt;
            key_strobe  <= w_enter_held | w_rpt_fire;
        end
    end
endmodule
